// File: rtl/br_redirect_if.sv
// Branch request / redirect bundle between the decode side, the EX-stage
// branch controller and the fetch-redirect consumer.
interface br_redirect_if #(
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned DIN_W = 26;
    localparam int unsigned REG_W = 5;

    // Branch request
    logic              br_valid;
    logic              br_ready;
    logic [XLEN-1:0]   br_pc;
    logic [OP_W-1:0]   br_op;
    logic [DIN_W-1:0]  br_din;
    logic [XLEN-1:0]   br_rj;
    logic [XLEN-1:0]   br_rd;
    logic              br_pred_taken;
    logic [XLEN-1:0]   br_pred_target;

    // Redirect to IF
    logic              redir_valid;
    logic              redir_ready;
    logic [XLEN-1:0]   redir_target;
    logic              flush;

    // Link write, fault and resolution reporting
    logic              link_we;
    logic [REG_W-1:0]  link_addr;
    logic [XLEN-1:0]   link_wdata;
    logic              adef;
    logic              resp_valid;
    logic              resp_taken;
    logic [CNT_W-1:0]  mispred_cnt;

    // Requester / redirect consumer side
    modport master (
        output br_valid, br_pc, br_op, br_din, br_rj, br_rd,
               br_pred_taken, br_pred_target, redir_ready,
        input  br_ready, redir_valid, redir_target, flush,
               link_we, link_addr, link_wdata, adef,
               resp_valid, resp_taken, mispred_cnt
    );

    // Branch controller side
    modport slave (
        input  br_valid, br_pc, br_op, br_din, br_rj, br_rd,
               br_pred_taken, br_pred_target, redir_ready,
        output br_ready, redir_valid, redir_target, flush,
               link_we, link_addr, link_wdata, adef,
               resp_valid, resp_taken, mispred_cnt
    );
endinterface

// File: rtl/br_redirect_ctrl.sv
// EX-stage branch resolution and redirect controller.
// The branch is resolved from the request fields at the acceptance edge so
// that every resolution output is a flop presented in the RESOLVE cycle;
// br_ready is the only output decoded from state.
module br_redirect_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h1C00_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    br_redirect_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned REG_W = 5;

    localparam logic [OP_W-1:0] OP_BEQ  = 4'd0;
    localparam logic [OP_W-1:0] OP_BNE  = 4'd1;
    localparam logic [OP_W-1:0] OP_BLT  = 4'd2;
    localparam logic [OP_W-1:0] OP_BGE  = 4'd3;
    localparam logic [OP_W-1:0] OP_BLTU = 4'd4;
    localparam logic [OP_W-1:0] OP_BGEU = 4'd5;
    localparam logic [OP_W-1:0] OP_B    = 4'd6;
    localparam logic [OP_W-1:0] OP_BL   = 4'd7;
    localparam logic [OP_W-1:0] OP_JIRL = 4'd8;

    localparam logic [REG_W-1:0] LINK_REG_BL = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESOLVE,
        ST_REDIRECT
    } state_e;

    state_e            state_q, state_d;
    logic              redir_valid_q, redir_valid_d;
    logic [XLEN-1:0]   redir_target_q, redir_target_d;
    logic              flush_q, flush_d;
    logic              link_we_q, link_we_d;
    logic [REG_W-1:0]  link_addr_q, link_addr_d;
    logic [XLEN-1:0]   link_wdata_q, link_wdata_d;
    logic              adef_q, adef_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_taken_q, resp_taken_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept_c;
    logic [XLEN-1:0]   offs_c;
    logic [XLEN-1:0]   base_c;
    logic [XLEN-1:0]   target_c;
    logic [XLEN-1:0]   pc_plus4_c;
    logic              taken_c;
    logic              link_c;
    logic [REG_W-1:0]  link_addr_c;
    logic              adef_c;
    logic              mis_c;
    logic              redirect_c;

    assign accept_c = bus.br_valid && (state_q == ST_IDLE);

    // Resolve the presented request: offset, target, direction, link, mispredict
    always_comb begin
        offs_c      = {{14{bus.br_din[25]}}, bus.br_din[25:10], 2'b00};
        base_c      = bus.br_pc;
        taken_c     = 1'b0;
        link_c      = 1'b0;
        case (bus.br_op)
            OP_BEQ:  taken_c = (bus.br_rj == bus.br_rd);
            OP_BNE:  taken_c = (bus.br_rj != bus.br_rd);
            OP_BLT:  taken_c = ($signed(bus.br_rj) <  $signed(bus.br_rd));
            OP_BGE:  taken_c = ($signed(bus.br_rj) >= $signed(bus.br_rd));
            OP_BLTU: taken_c = (bus.br_rj <  bus.br_rd);
            OP_BGEU: taken_c = (bus.br_rj >= bus.br_rd);
            OP_B: begin
                taken_c = 1'b1;
                offs_c  = {{4{bus.br_din[9]}}, bus.br_din[9:0], bus.br_din[25:10], 2'b00};
            end
            OP_BL: begin
                taken_c = 1'b1;
                link_c  = 1'b1;
                offs_c  = {{4{bus.br_din[9]}}, bus.br_din[9:0], bus.br_din[25:10], 2'b00};
            end
            OP_JIRL: begin
                taken_c = 1'b1;
                link_c  = 1'b1;
                base_c  = bus.br_rj;
            end
            default: ;
        endcase
        target_c    = base_c + offs_c;
        pc_plus4_c  = bus.br_pc + XLEN'(4);
        link_addr_c = (bus.br_op == OP_BL) ? LINK_REG_BL : bus.br_din[4:0];
        adef_c      = taken_c && (target_c[1:0] != 2'b00);
        // Illegal ops resolve not-taken, so only the predicted direction matters
        mis_c       = (taken_c != bus.br_pred_taken)
                    || (taken_c && bus.br_pred_taken && (target_c != bus.br_pred_target));
        // An alignment fault takes precedence over any redirect
        redirect_c  = mis_c && !adef_c;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        redir_valid_d  = 1'b0;
        redir_target_d = redir_target_q;
        flush_d        = 1'b0;
        link_we_d      = 1'b0;
        link_addr_d    = link_addr_q;
        link_wdata_d   = link_wdata_q;
        adef_d         = 1'b0;
        resp_valid_d   = 1'b0;
        resp_taken_d   = resp_taken_q;
        cnt_d          = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d      = ST_RESOLVE;
                    resp_valid_d = 1'b1;
                    resp_taken_d = taken_c;
                    adef_d       = adef_c;
                    if (link_c) begin
                        link_we_d    = 1'b1;
                        link_addr_d  = link_addr_c;
                        link_wdata_d = pc_plus4_c;
                    end
                    if (redirect_c) begin
                        redir_valid_d  = 1'b1;
                        flush_d        = 1'b1;
                        redir_target_d = taken_c ? target_c : pc_plus4_c;
                        cnt_d          = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RESOLVE: begin
                if (redir_valid_q) begin
                    if (bus.redir_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d       = ST_REDIRECT;
                        redir_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (bus.redir_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    redir_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            redir_valid_q  <= 1'b0;
            redir_target_q <= PC_RESET;
            flush_q        <= 1'b0;
            link_we_q      <= 1'b0;
            link_addr_q    <= '0;
            link_wdata_q   <= '0;
            adef_q         <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_taken_q   <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            redir_valid_q  <= redir_valid_d;
            redir_target_q <= redir_target_d;
            flush_q        <= flush_d;
            link_we_q      <= link_we_d;
            link_addr_q    <= link_addr_d;
            link_wdata_q   <= link_wdata_d;
            adef_q         <= adef_d;
            resp_valid_q   <= resp_valid_d;
            resp_taken_q   <= resp_taken_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bus.br_ready     = (state_q == ST_IDLE);
    assign bus.redir_valid  = redir_valid_q;
    assign bus.redir_target = redir_target_q;
    assign bus.flush        = flush_q;
    assign bus.link_we      = link_we_q;
    assign bus.link_addr    = link_addr_q;
    assign bus.link_wdata   = link_wdata_q;
    assign bus.adef         = adef_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_taken   = resp_taken_q;
    assign bus.mispred_cnt  = cnt_q;

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Bench for br_redirect_ctrl: directed vector table, reset-in-REDIRECT
// sequence, then randomized branches against a behavioural model.
module tb_br_redirect_ctrl;
    localparam logic [31:0] PC_RESET = 32'h1C00_0000;
    localparam int unsigned CNT_W    = 4;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] pc;
        logic [25:0] din;
        logic [31:0] rj;
        logic [31:0] rd;
        logic        pt;
        logic [31:0] ptgt;
    } req_t;

    typedef struct packed {
        logic        taken;
        logic        redir;
        logic        adef;
        logic        link_we;
        logic [4:0]  link_addr;
        logic [31:0] link_wdata;
        logic [31:0] redir_target;
    } exp_t;

    typedef struct {
        string name;
        req_t  req;
        exp_t  exp;
        int    stall;
    } vec_t;

    logic clk;
    logic rst_n;

    br_redirect_if #(.CNT_W(CNT_W)) bus ();

    br_redirect_ctrl #(.PC_RESET(PC_RESET), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Tracked architectural state of the controller outputs
    logic [CNT_W-1:0] m_cnt;
    logic [31:0]      m_rt;
    logic [4:0]       m_la;
    logic [31:0]      m_lw;

    vec_t vt[10];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural reference: signed immediates scaled by 4, plain comparisons
    function automatic exp_t model(input req_t r);
        exp_t        e;
        logic signed [25:0] i26;
        logic signed [15:0] i16;
        int          offs;
        logic [31:0] tgt;
        logic        tk;
        logic        mis;
        i26  = {r.din[9:0], r.din[25:10]};
        i16  = r.din[25:10];
        offs = (r.op == 4'd6 || r.op == 4'd7) ? int'(i26) * 4 : int'(i16) * 4;
        tgt  = ((r.op == 4'd8) ? r.rj : r.pc) + 32'(offs);
        case (r.op)
            4'd0: tk = (r.rj == r.rd);
            4'd1: tk = (r.rj != r.rd);
            4'd2: tk = ($signed(r.rj) <  $signed(r.rd));
            4'd3: tk = ($signed(r.rj) >= $signed(r.rd));
            4'd4: tk = (r.rj <  r.rd);
            4'd5: tk = (r.rj >= r.rd);
            4'd6, 4'd7, 4'd8: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        e.taken        = tk;
        e.adef         = tk && (tgt % 4 != 0);
        mis            = (tk != r.pt) || (tk && tgt != r.ptgt);
        e.redir        = mis && !e.adef;
        e.redir_target = tk ? tgt : r.pc + 32'd4;
        e.link_we      = (r.op == 4'd7) || (r.op == 4'd8);
        e.link_addr    = (r.op == 4'd7) ? 5'd1 : r.din[4:0];
        e.link_wdata   = r.pc + 32'd4;
        return e;
    endfunction

    task automatic model_reset();
        m_cnt = '0;
        m_rt  = PC_RESET;
        m_la  = '0;
        m_lw  = '0;
    endtask

    task automatic check_reset_state(input string name);
        chk({name, ".br_ready"},     32'(bus.br_ready),     32'd1);
        chk({name, ".redir_valid"},  32'(bus.redir_valid),  32'd0);
        chk({name, ".flush"},        32'(bus.flush),        32'd0);
        chk({name, ".resp_valid"},   32'(bus.resp_valid),   32'd0);
        chk({name, ".link_we"},      32'(bus.link_we),      32'd0);
        chk({name, ".adef"},         32'(bus.adef),         32'd0);
        chk({name, ".redir_target"}, bus.redir_target,      PC_RESET);
        chk({name, ".link_addr"},    32'(bus.link_addr),    32'd0);
        chk({name, ".link_wdata"},   bus.link_wdata,        32'd0);
        chk({name, ".mispred_cnt"},  32'(bus.mispred_cnt),  32'd0);
    endtask

    task automatic drive_req(input req_t r);
        bus.br_op          = r.op;
        bus.br_pc          = r.pc;
        bus.br_din         = r.din;
        bus.br_rj          = r.rj;
        bus.br_rd          = r.rd;
        bus.br_pred_taken  = r.pt;
        bus.br_pred_target = r.ptgt;
        bus.br_valid       = 1'b1;
    endtask

    // Garbage on the request lines once the handshake is done
    task automatic scramble_req();
        bus.br_valid       = 1'b0;
        bus.br_op          = 4'($urandom);
        bus.br_pc          = $urandom;
        bus.br_din         = 26'($urandom);
        bus.br_rj          = $urandom;
        bus.br_rd          = $urandom;
        bus.br_pred_taken  = 1'($urandom);
        bus.br_pred_target = $urandom;
    endtask

    // One branch: accept, check resolution, run the redirect stall, check return to idle
    task automatic run_branch(input string name, input req_t r, input exp_t e, input int stall);
        int guard;
        guard = 0;
        while (!bus.br_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.br_ready) begin
            chk({name, ".ready_timeout"}, 32'(bus.br_ready), 32'd1);
            return;
        end
        drive_req(r);
        bus.redir_ready = 1'b0;
        @(posedge clk);
        #1;
        scramble_req();

        if (e.redir) begin
            m_rt  = e.redir_target;
            m_cnt = (m_cnt == {CNT_W{1'b1}}) ? m_cnt : m_cnt + CNT_W'(1);
        end
        if (e.link_we) begin
            m_la = e.link_addr;
            m_lw = e.link_wdata;
        end

        @(negedge clk);
        chk({name, ".resp_valid"},   32'(bus.resp_valid),  32'd1);
        chk({name, ".resp_taken"},   32'(bus.resp_taken),  32'(e.taken));
        chk({name, ".adef"},         32'(bus.adef),        32'(e.adef));
        chk({name, ".link_we"},      32'(bus.link_we),     32'(e.link_we));
        chk({name, ".link_addr"},    32'(bus.link_addr),   32'(m_la));
        chk({name, ".link_wdata"},   bus.link_wdata,       m_lw);
        chk({name, ".mispred_cnt"},  32'(bus.mispred_cnt), 32'(m_cnt));
        chk({name, ".br_ready_n1"},  32'(bus.br_ready),    32'd0);

        if (e.redir) begin
            for (int k = 0; k <= stall; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    chk({name, ".flush_hold"},  32'(bus.flush),      32'd0);
                    chk({name, ".resp_hold"},   32'(bus.resp_valid), 32'd0);
                    chk({name, ".br_ready_st"}, 32'(bus.br_ready),   32'd0);
                end
                chk({name, ".redir_valid"},  32'(bus.redir_valid), 32'd1);
                chk({name, ".redir_target"}, bus.redir_target,     m_rt);
                if (k == 0) chk({name, ".flush"}, 32'(bus.flush), 32'd1);
                bus.redir_ready = (k == stall);
                @(posedge clk);
                #1;
            end
            bus.redir_ready = 1'b0;
        end else begin
            chk({name, ".redir_valid"},  32'(bus.redir_valid), 32'd0);
            chk({name, ".flush"},        32'(bus.flush),       32'd0);
            chk({name, ".redir_target"}, bus.redir_target,     m_rt);
            bus.redir_ready = 1'($urandom);
            @(posedge clk);
            #1;
            bus.redir_ready = 1'b0;
        end

        @(negedge clk);
        chk({name, ".br_ready_idle"},  32'(bus.br_ready),    32'd1);
        chk({name, ".redir_off"},      32'(bus.redir_valid), 32'd0);
        chk({name, ".resp_off"},       32'(bus.resp_valid),  32'd0);
    endtask

    initial begin
        req_t r;
        exp_t e;

        // Directed table: {name, request, expected, redirect stall cycles}
        vt[0] = '{"beq_mis",   '{4'd0, 32'h1C00_0100, {16'hFFFF, 10'h000}, 32'd5, 32'd5, 1'b0, 32'h0},
                               '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_00FC}, 0};
        vt[1] = '{"b_hit",     '{4'd6, 32'h1C00_0000, {16'h0000, 10'h200}, 32'd0, 32'd0, 1'b1, 32'h1400_0000},
                               '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0}, 0};
        vt[2] = '{"bl_stall",  '{4'd7, 32'h1C00_0010, {16'h0010, 10'h000}, 32'd0, 32'd0, 1'b0, 32'h0},
                               '{1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h1C00_0014, 32'h1C00_0050}, 3};
        vt[3] = '{"jirl_adef", '{4'd8, 32'h1C00_0200, {16'h0000, 10'h001}, 32'h1C00_1002, 32'd0, 1'b0, 32'h0},
                               '{1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h1C00_0204, 32'h0}, 0};
        vt[4] = '{"bltu_nt",   '{4'd4, 32'h1C00_0300, {16'h0004, 10'h000}, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0},
                               '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0}, 0};
        vt[5] = '{"blt_tk",    '{4'd2, 32'h1C00_0400, {16'h0004, 10'h000}, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0},
                               '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_0410}, 1};
        vt[6] = '{"bge_nt",    '{4'd3, 32'h1C00_0500, {16'h0004, 10'h000}, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h1C00_0510},
                               '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_0504}, 0};
        vt[7] = '{"bne_tgt",   '{4'd1, 32'h1C00_0600, {16'h0008, 10'h000}, 32'd1, 32'd2, 1'b1, 32'h1C00_0604},
                               '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_0620}, 0};
        vt[8] = '{"illegal_a", '{4'hA, 32'h1C00_0700, {16'h0004, 10'h000}, 32'd3, 32'd3, 1'b1, 32'h0},
                               '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_0704}, 2};
        vt[9] = '{"bgeu_nt",   '{4'd5, 32'h1C00_0800, {16'h0004, 10'h000}, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'h0},
                               '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0}, 0};

        rst_n           = 1'b0;
        bus.redir_ready = 1'b0;
        drive_req('0);
        bus.br_valid    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("reset");

        for (int i = 0; i < 8; i++) begin
            run_branch(vt[i].name, vt[i].req, vt[i].exp, vt[i].stall);
        end

        // Reset while a redirect is pending drops it
        drive_req(vt[0].req);
        bus.redir_ready = 1'b0;
        @(posedge clk);
        #1;
        scramble_req();
        @(negedge clk);
        chk("rst_seq.resolve_redir", 32'(bus.redir_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_seq.redirect_redir", 32'(bus.redir_valid), 32'd1);
        chk("rst_seq.redirect_ready", 32'(bus.br_ready),    32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_state("rst_seq");
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_seq.dropped", 32'(bus.redir_valid), 32'd0);

        for (int i = 8; i < 10; i++) begin
            run_branch(vt[i].name, vt[i].req, vt[i].exp, vt[i].stall);
        end

        // Randomized branches against the behavioural model
        for (int i = 0; i < 250; i++) begin
            r.op   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            r.pc   = $urandom & 32'hFFFF_FFFC;
            r.din  = 26'($urandom);
            r.rj   = $urandom;
            if ($urandom_range(0, 3) == 0) r.rj = r.rj & 32'hFFFF_FFFC;
            r.rd   = ($urandom_range(0, 3) == 0) ? r.rj : $urandom;
            r.pt   = 1'($urandom);
            r.ptgt = $urandom;
            e      = model(r);
            if (e.taken && $urandom_range(0, 1) == 1) r.ptgt = e.redir_target;
            e      = model(r);
            run_branch("rand", r, e, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
